// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with a full-depth occupancy counter, programmable almost-full/almost-empty
// thresholds, one-cycle error pulses and a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int p_DATA_WIDTH             = 8,
  parameter int p_ADDRESS_WIDTH          = 4,
  parameter int p_ALMOST_FULL_THRESHOLD  = 12,
  parameter int p_ALMOST_EMPTY_THRESHOLD = 4,
  parameter int p_FWFT                   = 0
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       i_WRITE_REQUEST,
  input  logic                       i_READ_REQUEST,
  input  logic [p_DATA_WIDTH-1:0]    i_INPUT,
  output logic [p_DATA_WIDTH-1:0]    o_OUTPUT,
  output logic                       o_OUTPUT_VALID,
  output logic                       o_FIFO_EMPTY,
  output logic                       o_FIFO_FULL,
  output logic                       o_FIFO_ALMOST_EMPTY,
  output logic                       o_FIFO_ALMOST_FULL,
  output logic [p_ADDRESS_WIDTH:0]   o_FILL_COUNT,
  output logic                       o_OVERFLOW,
  output logic                       o_UNDERFLOW
);

  localparam int D = 1 << p_ADDRESS_WIDTH;
  localparam logic [p_ADDRESS_WIDTH:0]   c_DEPTH   = D[p_ADDRESS_WIDTH:0];
  localparam logic [p_ADDRESS_WIDTH:0]   c_AF      = p_ALMOST_FULL_THRESHOLD[p_ADDRESS_WIDTH:0];
  localparam logic [p_ADDRESS_WIDTH:0]   c_AE      = p_ALMOST_EMPTY_THRESHOLD[p_ADDRESS_WIDTH:0];
  localparam logic [p_ADDRESS_WIDTH-1:0] c_PTR_ONE = p_ADDRESS_WIDTH'(1);
  localparam logic [p_ADDRESS_WIDTH:0]   c_CNT_ONE = (p_ADDRESS_WIDTH+1)'(1);

  // Out-of-range thresholds would make a flag stuck; refuse to elaborate.
  if (p_ALMOST_FULL_THRESHOLD < 1 || p_ALMOST_FULL_THRESHOLD > D) begin : g_bad_af
    $error("sync_fifo_param: p_ALMOST_FULL_THRESHOLD out of range 1..D");
  end
  if (p_ALMOST_EMPTY_THRESHOLD < 0 || p_ALMOST_EMPTY_THRESHOLD > D - 1) begin : g_bad_ae
    $error("sync_fifo_param: p_ALMOST_EMPTY_THRESHOLD out of range 0..D-1");
  end

  logic [p_DATA_WIDTH-1:0]    mem [0:D-1];
  logic [p_ADDRESS_WIDTH-1:0] wr_ptr;
  logic [p_ADDRESS_WIDTH-1:0] rd_ptr;
  logic [p_ADDRESS_WIDTH:0]   count;
  logic                       overflow_q;
  logic                       underflow_q;
  logic                       wr_ok;
  logic                       rd_ok;

  // Request semantics: a request is a single-cycle strobe sampled at the rising edge; it is
  // accepted at that edge iff the qualification below holds, otherwise it is dropped and
  // flagged by a one-cycle error pulse. A read on empty is never accepted; a write on full
  // is accepted only when a read is accepted in the same cycle (the freed slot takes it).
  always_comb begin
    rd_ok = i_READ_REQUEST && (count != '0);
    wr_ok = i_WRITE_REQUEST && ((count < c_DEPTH) || rd_ok);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + c_PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + c_PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + c_CNT_ONE;
        2'b01:   count <= count - c_CNT_ONE;
        default: count <= count;
      endcase
      overflow_q  <= i_WRITE_REQUEST && !wr_ok;
      underflow_q <= i_READ_REQUEST && !rd_ok;
    end
  end

  // Storage is not reset; a reset edge suppresses the write.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET && wr_ok) mem[wr_ptr] <= i_INPUT;
  end

  always_comb begin
    o_FILL_COUNT        = count;
    o_FIFO_EMPTY        = (count == '0);
    o_FIFO_FULL         = (count == c_DEPTH);
    o_FIFO_ALMOST_EMPTY = (count <= c_AE);
    o_FIFO_ALMOST_FULL  = (count >= c_AF);
    o_OVERFLOW          = overflow_q;
    o_UNDERFLOW         = underflow_q;
  end

  if (p_FWFT != 0) begin : g_fwft
    // Head word is always on the output; a read acknowledges and pops it.
    assign o_OUTPUT       = mem[rd_ptr];
    assign o_OUTPUT_VALID = (count != '0);
  end else begin : g_std
    logic [p_DATA_WIDTH-1:0] out_q;
    logic                    valid_q;

    always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        if (rd_ok) out_q <= mem[rd_ptr];
        valid_q <= rd_ok;
      end
    end

    assign o_OUTPUT       = out_q;
    assign o_OUTPUT_VALID = valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-mode and an FWFT-mode instance (D=16, AF=12, AE=4)
// checked against hand-computed values and an expected-data queue.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_s, rd_s, wr_f, rd_f;
  logic [7:0] din_s, din_f;

  logic [7:0] out_s, out_f;
  logic       vld_s, vld_f, emp_s, emp_f, ful_s, ful_f;
  logic       ae_s, ae_f, af_s, af_f, ovf_s, ovf_f, unf_s, unf_f;
  logic [4:0] cnt_s, cnt_f;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  always #5 clk = ~clk;

  sync_fifo_param #(.p_FWFT(0)) dut_s (
    .i_CLK(clk), .i_RESET(rst), .i_WRITE_REQUEST(wr_s), .i_READ_REQUEST(rd_s),
    .i_INPUT(din_s), .o_OUTPUT(out_s), .o_OUTPUT_VALID(vld_s), .o_FIFO_EMPTY(emp_s),
    .o_FIFO_FULL(ful_s), .o_FIFO_ALMOST_EMPTY(ae_s), .o_FIFO_ALMOST_FULL(af_s),
    .o_FILL_COUNT(cnt_s), .o_OVERFLOW(ovf_s), .o_UNDERFLOW(unf_s)
  );

  sync_fifo_param #(.p_FWFT(1)) dut_f (
    .i_CLK(clk), .i_RESET(rst), .i_WRITE_REQUEST(wr_f), .i_READ_REQUEST(rd_f),
    .i_INPUT(din_f), .o_OUTPUT(out_f), .o_OUTPUT_VALID(vld_f), .o_FIFO_EMPTY(emp_f),
    .o_FIFO_FULL(ful_f), .o_FIFO_ALMOST_EMPTY(ae_f), .o_FIFO_ALMOST_FULL(af_f),
    .o_FILL_COUNT(cnt_f), .o_OVERFLOW(ovf_f), .o_UNDERFLOW(unf_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle of requests, take the edge, sample 1 time unit later.
  task automatic step_s(input logic w, input logic r, input logic [7:0] d);
    wr_s = w; rd_s = r; din_s = d;
    @(posedge clk); #1;
    wr_s = 1'b0; rd_s = 1'b0;
  endtask

  task automatic step_f(input logic w, input logic r, input logic [7:0] d);
    wr_f = w; rd_f = r; din_f = d;
    @(posedge clk); #1;
    wr_f = 1'b0; rd_f = 1'b0;
  endtask

  task automatic drain_s(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step_s(1'b0, 1'b1, 8'h00);
      exp_w = exp_q.pop_front();
      check({tag, "_data"}, out_s, exp_w);
      check({tag, "_valid"}, vld_s, 1);
      check({tag, "_count"}, cnt_s, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; wr_s = 0; rd_s = 0; wr_f = 0; rd_f = 0; din_s = 0; din_f = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step_s(1'b0, 1'b0, 8'h00);

    // Reset then idle
    check("rst_empty", emp_s, 1);   check("rst_ae", ae_s, 1);
    check("rst_full", ful_s, 0);    check("rst_af", af_s, 0);
    check("rst_count", cnt_s, 0);   check("rst_valid", vld_s, 0);
    check("rst_out", out_s, 0);     check("rst_ovf", ovf_s, 0);
    check("rst_unf", unf_s, 0);     check("rst_f_valid", vld_f, 0);
    check("rst_f_empty", emp_f, 1);

    // Fill with 0x00..0x0F, watching each threshold crossing
    for (int k = 1; k <= 16; k++) begin
      step_s(1'b1, 1'b0, 8'(k - 1));
      exp_q.push_back(8'(k - 1));
      check("fill_count", cnt_s, k);
      check("fill_ae", ae_s, (k <= 4) ? 1 : 0);
      check("fill_af", af_s, (k >= 12) ? 1 : 0);
      check("fill_full", ful_s, (k == 16) ? 1 : 0);
      check("fill_empty", emp_s, 0);
    end
    step_s(1'b1, 1'b0, 8'hAA);
    check("ovf_pulse", ovf_s, 1);
    check("ovf_count", cnt_s, 16);
    step_s(1'b0, 1'b0, 8'h00);
    check("ovf_clear", ovf_s, 0);
    check("ovf_count_hold", cnt_s, 16);
    drain_s(16, "drain1");
    step_s(1'b0, 1'b0, 8'h00);
    check("drain1_idle_valid", vld_s, 0);
    check("drain1_empty", emp_s, 1);

    // Single word: 1-cycle read latency, then underflow on empty
    step_s(1'b1, 1'b0, 8'h5A);
    check("one_count", cnt_s, 1);
    check("one_valid_before_read", vld_s, 0);
    step_s(1'b0, 1'b1, 8'h00);
    check("one_data", out_s, 8'h5A);
    check("one_valid", vld_s, 1);
    step_s(1'b0, 1'b0, 8'h00);
    check("one_valid_drop", vld_s, 0);
    check("one_data_hold", out_s, 8'h5A);
    step_s(1'b0, 1'b1, 8'h00);
    check("unf_pulse", unf_s, 1);
    check("unf_count", cnt_s, 0);
    check("unf_valid", vld_s, 0);
    step_s(1'b0, 1'b0, 8'h00);
    check("unf_clear", unf_s, 0);

    // Full with simultaneous read+write; pointers wrap during the drain
    for (int k = 0; k < 16; k++) begin
      step_s(1'b1, 1'b0, 8'(8'h20 + k));
      exp_q.push_back(8'(8'h20 + k));
    end
    check("full2", ful_s, 1);
    step_s(1'b1, 1'b1, 8'h77);
    exp_w = exp_q.pop_front();
    exp_q.push_back(8'h77);
    check("rw_full_data", out_s, exp_w);
    check("rw_full_valid", vld_s, 1);
    check("rw_full_count", cnt_s, 16);
    check("rw_full_no_ovf", ovf_s, 0);
    step_s(1'b0, 1'b0, 8'h00);
    check("rw_full_no_ovf2", ovf_s, 0);
    drain_s(16, "drain2");
    check("drain2_last", out_s, 8'h77);

    // Reset mid-stream at count 9 with both requests high
    for (int k = 0; k < 9; k++) step_s(1'b1, 1'b0, 8'(8'h40 + k));
    check("mid_count", cnt_s, 9);
    rst = 1'b1;
    step_s(1'b1, 1'b1, 8'h99);
    rst = 1'b0;
    exp_q.delete();
    check("mrst_count", cnt_s, 0);  check("mrst_empty", emp_s, 1);
    check("mrst_ovf", ovf_s, 0);    check("mrst_unf", unf_s, 0);
    check("mrst_valid", vld_s, 0);  check("mrst_out", out_s, 0);
    // Write+read on empty: write lands, read is rejected
    step_s(1'b1, 1'b1, 8'h11);
    check("rw_empty_count", cnt_s, 1);
    check("rw_empty_unf", unf_s, 1);
    check("rw_empty_valid", vld_s, 0);
    step_s(1'b0, 1'b1, 8'h00);
    check("post_rst_data", out_s, 8'h11);
    check("post_rst_valid", vld_s, 1);
    check("post_rst_unf_clear", unf_s, 0);

    // FWFT instance
    step_f(1'b1, 1'b0, 8'h3C);
    check("fwft_data", out_f, 8'h3C);
    check("fwft_valid", vld_f, 1);
    check("fwft_count", cnt_f, 1);
    step_f(1'b0, 1'b0, 8'h00);
    check("fwft_hold_valid", vld_f, 1);
    step_f(1'b0, 1'b1, 8'h00);
    check("fwft_pop_valid", vld_f, 0);
    check("fwft_pop_empty", emp_f, 1);
    step_f(1'b1, 1'b0, 8'hA1);
    step_f(1'b1, 1'b0, 8'hB2);
    check("fwft_head", out_f, 8'hA1);
    check("fwft_count2", cnt_f, 2);
    step_f(1'b0, 1'b1, 8'h00);
    check("fwft_next", out_f, 8'hB2);
    check("fwft_next_valid", vld_f, 1);
    step_f(1'b0, 1'b1, 8'h00);
    check("fwft_empty2", emp_f, 1);
    step_f(1'b0, 1'b1, 8'h00);
    check("fwft_unf", unf_f, 1);
    check("fwft_unf_count", cnt_f, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
